// File: rtl/core3_cpu_1_oci_dct_packer_pkg.sv
// Shared definitions for the OCI direct-compressed-trace path: frame geometry,
// packer state encoding and slot addressing helper.
package oci_trace_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned SLOTS  = 15;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUF_W  = CODE_W * SLOTS;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    ENDED
  } dct_state_e;

  // Bit position of the least significant bit of slot i inside a frame.
  function automatic int unsigned slot_lsb(input int unsigned i);
    return CODE_W * i;
  endfunction

endpackage

// File: rtl/core3_cpu_1_oci_dct_frame_reg.sv
// Frame output stage: holds one completed frame and presents it to the trace
// sink over valid/ready. Contents are zeroed once the sink consumes them.
module core3_cpu_1_oci_dct_frame_reg
  import oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count
);

  // Load a new frame (may coincide with draining the old one), else clear on consumption.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      dct_buffer  <= '0;
      dct_count   <= '0;
    end else if (load) begin
      frame_valid <= 1'b1;
      dct_buffer  <= load_buffer;
      dct_count   <= load_count;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
      dct_buffer  <= '0;
      dct_count   <= '0;
    end
  end

endmodule

// File: rtl/core3_cpu_1_oci_dct_packer.sv
// Producer side of the OCI DCT interface: packs 2-bit trace codes into 15-slot
// frames, hands them to the frame stage and sequences the end-of-test flush.
module core3_cpu_1_oci_dct_packer
  import oci_trace_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [1:0]       code,
  output logic             code_ready,
  input  logic             flush,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             test_ending,
  output logic             test_has_ended
);

  dct_state_e       state;
  logic             ready_q;
  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;

  logic [BUF_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;
  logic             frame_free;
  logic             flush_pend;
  logic             load;
  logic             fv_next;
  logic             drain_done;

  assign code_ready = ready_q;

  // Handoff decisions look at the accumulator including this cycle's code, so
  // the 15th code (or a code arriving with flush) leaves in the same cycle.
  always_comb begin
    accept  = code_valid & ready_q;
    acc_upd = acc;
    cnt_upd = acc_cnt;
    if (accept) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (acc_cnt == CNT_W'(i)) acc_upd[slot_lsb(i) +: CODE_W] = code;
      end
      cnt_upd = acc_cnt + 1'b1;
    end
    frame_free = !frame_valid | frame_ready;
    flush_pend = (state == DRAIN) | ((state == ACCUM) & flush);
    load       = frame_free & ((cnt_upd == CNT_W'(SLOTS)) | (flush_pend & (cnt_upd != '0)));
    cnt_nxt    = load ? '0 : cnt_upd;
    fv_next    = load | (frame_valid & !frame_ready);
    drain_done = flush_pend & (cnt_nxt == '0) & !fv_next;
  end

  // Accumulator: collect accepted codes, empty it when its contents move to the frame stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (load) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else begin
      acc     <= acc_upd;
      acc_cnt <= cnt_upd;
    end
  end

  // Flush sequencing FSM with registered code_ready and end-of-test flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ACCUM;
      ready_q        <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      test_ending <= 1'b0;
      case (state)
        ACCUM: begin
          if (flush) begin
            ready_q <= 1'b0;
            if (drain_done) begin
              state          <= ENDED;
              test_ending    <= 1'b1;
              test_has_ended <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            ready_q <= (cnt_nxt != CNT_W'(SLOTS));
          end
        end
        DRAIN: begin
          ready_q <= 1'b0;
          if (drain_done) begin
            state          <= ENDED;
            test_ending    <= 1'b1;
            test_has_ended <= 1'b1;
          end
        end
        ENDED: begin
          ready_q <= 1'b0;
        end
        default: begin
          state   <= ACCUM;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  core3_cpu_1_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_buffer (acc_upd),
    .load_count  (cnt_upd),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

endmodule

// File: tb/tb_core3_cpu_1_oci_dct_packer.sv
// Bench for the OCI DCT packer: flush table, directed corner sequences and a
// randomized run against a code-queue reference model.
module tb_core3_cpu_1_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        flush;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;

  int vecs = 0;
  int errs = 0;

  core3_cpu_1_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .code_valid     (code_valid),
    .code           (code),
    .code_ready     (code_ready),
    .flush          (flush),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic [1:0]  c;
    logic [3:0]  exp_cnt;
    logic [29:0] exp_buf;
    bit          has_frame;
  } flush_vec_t;

  flush_vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; code_valid = 1'b0; code = 2'b00; flush = 1'b0; frame_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic send(input logic [1:0] c);
    code_valid = 1'b1; code = c;
    tick;
    code_valid = 1'b0;
  endtask

  logic [1:0]  q[$];
  logic [29:0] exp_b;
  logic [29:0] prev_buf;
  logic [3:0]  prev_cnt;
  bit          hold;
  bit          acc_h, cons_h;
  int          waited;

  initial begin
    tbl[0] = '{n: 5,  c: 2'b11, exp_cnt: 4'd5,  exp_buf: 30'h000003FF, has_frame: 1'b1};
    tbl[1] = '{n: 1,  c: 2'b10, exp_cnt: 4'd1,  exp_buf: 30'h00000002, has_frame: 1'b1};
    tbl[2] = '{n: 14, c: 2'b11, exp_cnt: 4'd14, exp_buf: 30'h0FFFFFFF, has_frame: 1'b1};
    tbl[3] = '{n: 15, c: 2'b01, exp_cnt: 4'd15, exp_buf: 30'h15555555, has_frame: 1'b1};
    tbl[4] = '{n: 0,  c: 2'b00, exp_cnt: 4'd0,  exp_buf: 30'h00000000, has_frame: 1'b0};

    // Reset state, sampled while reset is held.
    reset = 1'b1; code_valid = 1'b0; code = 2'b00; flush = 1'b0; frame_ready = 1'b0;
    tick;
    chk("rst_code_ready", code_ready, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_buffer", dct_buffer, 0);
    chk("rst_count", dct_count, 0);
    chk("rst_test_ending", test_ending, 0);
    chk("rst_has_ended", test_has_ended, 0);
    reset = 1'b0;
    tick;

    // 1: 15 codes back-to-back, sink always ready.
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("t1_ready", code_ready, 1);
      chk("t1_no_frame_yet", frame_valid, 0);
      code_valid = 1'b1; code = 2'((i + 1) % 4);
      tick;
    end
    code_valid = 1'b0;
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_count", dct_count, 15);
    for (int s = 0; s < 15; s++) chk("t1_slot", dct_buffer[2*s +: 2], (s + 1) % 4);
    chk("t1_ready_after", code_ready, 1);
    tick;
    chk("t1_consumed", frame_valid, 0);
    chk("t1_zeroed", dct_buffer, 0);

    // 2: backpressure with 30 codes, then release.
    apply_reset;
    q.delete();
    for (int i = 0; i < 30; i++) begin
      chk("t2_ready", code_ready, 1);
      code_valid = 1'b1; code = 2'($urandom);
      q.push_back(code);
      tick;
    end
    chk("t2_ready_31st", code_ready, 0);
    code_valid = 1'b0;
    for (int s = 0; s < 15; s++) exp_b[2*s +: 2] = q[s];
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_valid", frame_valid, 1);
      chk("t2_hold_buf", dct_buffer, exp_b);
      chk("t2_hold_count", dct_count, 15);
      tick;
    end
    frame_ready = 1'b1;
    tick;
    frame_ready = 1'b0;
    for (int s = 0; s < 15; s++) exp_b[2*s +: 2] = q[15 + s];
    chk("t2_frame2_valid", frame_valid, 1);
    chk("t2_frame2_buf", dct_buffer, exp_b);
    chk("t2_ready_again", code_ready, 1);
    frame_ready = 1'b1;
    tick;
    frame_ready = 1'b0;
    chk("t2_drained", frame_valid, 0);

    // 3/4: flush table.
    for (int v = 0; v < 5; v++) begin
      apply_reset;
      for (int unsigned i = 0; i < tbl[v].n; i++) send(tbl[v].c);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      if (tbl[v].has_frame) begin
        waited = 0;
        while (!frame_valid && waited < 20) begin tick; waited++; end
        chk("tbl_frame_valid", frame_valid, 1);
        chk("tbl_count", dct_count, tbl[v].exp_cnt);
        chk("tbl_buffer", dct_buffer, tbl[v].exp_buf);
        chk("tbl_ready_drain", code_ready, 0);
        chk("tbl_no_end_yet", test_ending, 0);
        frame_ready = 1'b1;
        tick;
        frame_ready = 1'b0;
        chk("tbl_consumed", frame_valid, 0);
      end
      chk("tbl_ending_pulse", test_ending, 1);
      chk("tbl_has_ended", test_has_ended, 1);
      code_valid = 1'b1; flush = 1'b1;
      tick;
      chk("tbl_ending_off", test_ending, 0);
      chk("tbl_has_ended_sticky", test_has_ended, 1);
      chk("tbl_ready_ended", code_ready, 0);
      chk("tbl_no_extra_frame", frame_valid, 0);
      code_valid = 1'b0; flush = 1'b0;
    end

    // 5: flush together with the 15th code.
    apply_reset;
    for (int i = 0; i < 14; i++) send(2'b01);
    code_valid = 1'b1; code = 2'b10; flush = 1'b1;
    tick;
    code_valid = 1'b0; flush = 1'b0;
    chk("t5_frame_valid", frame_valid, 1);
    chk("t5_count", dct_count, 15);
    chk("t5_buffer", dct_buffer, 30'h25555555);
    tick;
    chk("t5_no_end_early", test_ending, 0);
    frame_ready = 1'b1;
    tick;
    chk("t5_consumed", frame_valid, 0);
    chk("t5_ending", test_ending, 1);
    tick;
    chk("t5_no_extra_frame", frame_valid, 0);
    chk("t5_has_ended", test_has_ended, 1);
    frame_ready = 1'b0;

    // 6: asynchronous reset with a pending frame and 7 buffered codes.
    apply_reset;
    for (int i = 0; i < 22; i++) send(2'b11);
    chk("t6_pending", frame_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", frame_valid, 0);
    chk("t6_async_buf", dct_buffer, 0);
    chk("t6_async_count", dct_count, 0);
    chk("t6_async_ready", code_ready, 0);
    tick;
    reset = 1'b0;
    tick;
    chk("t6_empty_after", frame_valid, 0);
    for (int i = 0; i < 15; i++) send(2'b10);
    chk("t6_new_valid", frame_valid, 1);
    chk("t6_new_buf", dct_buffer, 30'h2AAAAAAA);
    chk("t6_new_count", dct_count, 15);

    // Randomized traffic against the code-queue model (no flush).
    apply_reset;
    q.delete();
    hold = 1'b0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      chk("rnd_frame_valid", frame_valid, q.size() >= 15);
      chk("rnd_code_ready", code_ready, q.size() != 30);
      if (hold) begin
        chk("rnd_stable_buf", dct_buffer, prev_buf);
        chk("rnd_stable_cnt", dct_count, prev_cnt);
      end
      code_valid  = ($urandom_range(0, 3) != 0);
      code        = 2'($urandom);
      frame_ready = (cyc < 600) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      acc_h  = code_valid & code_ready;
      cons_h = frame_valid & frame_ready;
      if (cons_h && q.size() >= 15) begin
        chk("rnd_count", dct_count, 15);
        for (int s = 0; s < 15; s++) exp_b[2*s +: 2] = q[s];
        chk("rnd_buffer", dct_buffer, exp_b);
        for (int s = 0; s < 15; s++) void'(q.pop_front());
      end
      if (acc_h) q.push_back(code);
      hold     = frame_valid & !frame_ready;
      prev_buf = dct_buffer;
      prev_cnt = dct_count;
      tick;
    end
    code_valid = 1'b0; frame_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
